// File: rtl/param_sequencer_fsm_if.sv
// Bus between the program sequencer and its instruction memory / datapath.
// The sequencer takes the master modport; memory/datapath models take the slave modport.
interface param_sequencer_fsm_if #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 3,
  parameter int REG_W  = 2,
  parameter int IMM_W  = 8,
  parameter int CNT_W  = 16
);
  localparam int INSTR_W = OPC_W + 2*REG_W + 1 + IMM_W;

  logic               start;
  logic [3:0]         alu_flags;
  logic [INSTR_W-1:0] instr_rdata;
  logic [ADDR_W-1:0]  instr_addr;
  logic               WE;
  logic               ALUorM;
  logic [2:0]         ALUCntr;
  logic               ALUSrc2;
  logic [REG_W-1:0]   RDst3;
  logic [REG_W-1:0]   RSrc1;
  logic [IMM_W-1:0]   Src2;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   instr_count;
  logic [2:0]         state;

  modport master (
    input  start, alu_flags, instr_rdata,
    output instr_addr, WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
           busy, done, instr_count, state
  );

  modport slave (
    output start, alu_flags, instr_rdata,
    input  instr_addr, WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
           busy, done, instr_count, state
  );
endinterface

// File: rtl/param_sequencer_fsm.sv
// Multi-cycle program sequencer: FETCH/DECODE/EXEC per instruction, conditional branch on
// registered ALU flags, HALT -> DONE. Optional single-step WAIT state via CTRL_SEQ_STEP_EN.
module param_sequencer_fsm #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 3,
  parameter int REG_W  = 2,
  parameter int IMM_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef CTRL_SEQ_STEP_EN
  input  logic step,
`endif
  param_sequencer_fsm_if.master bus
);
  localparam int INSTR_W = OPC_W + 2*REG_W + 1 + IMM_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OPC_W-1:0]   opc;
  logic [REG_W-1:0]   rdst;
  logic [REG_W-1:0]   rsrc;
  logic [IMM_W-1:0]   imm;
  logic [3:0]         flag_sh;
  logic               we, aluorm;
  logic [2:0]         alucntr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    return c + CNT_W'(1);
  endfunction

  assign opc  = ir_q[INSTR_W-1 -: OPC_W];
  assign rdst = ir_q[IMM_W+1+2*REG_W-1 -: REG_W];
  assign rsrc = ir_q[IMM_W+REG_W -: REG_W];
  assign imm  = ir_q[IMM_W-1:0];

  // Register selects a flag bit {N,Z,C,V}[idx]; RSrc1[0] inverts the condition.
  assign flag_sh = flag_q >> rdst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    aluorm  = 1'b0;
    alucntr = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
          flag_d  = '0;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = bus.instr_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = sat_inc(cnt_q);
        pc_d  = pc_q + ADDR_W'(1);
`ifdef CTRL_SEQ_STEP_EN
        state_d = S_WAIT;
`else
        state_d = S_FETCH;
`endif
        if (opc < OP_LDI) begin
          we      = 1'b1;
          alucntr = 3'(opc);
          flag_d  = bus.alu_flags;
        end else if (opc == OP_LDI) begin
          we     = 1'b1;
          aluorm = 1'b1;
        end else if (opc == OP_BR) begin
          if (flag_sh[0] ^ rsrc[0]) pc_d = ADDR_W'(imm);
        end else if (opc == OP_HALT) begin
          pc_d    = pc_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_WAIT: begin
`ifdef CTRL_SEQ_STEP_EN
        if (step) state_d = S_FETCH;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.WE          = we;
  assign bus.ALUorM      = aluorm;
  assign bus.ALUCntr     = alucntr;
  assign bus.ALUSrc2     = ir_q[IMM_W];
  assign bus.RDst3       = rdst;
  assign bus.RSrc1       = rsrc;
  assign bus.Src2        = imm;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.instr_count = cnt_q;
  assign bus.state       = state_q;
endmodule
